slow_clock_monitor: RTL and testbench
=====================================

Name: slow_clock_monitor

Overview:
- Receive-side checker for the divided slow clock, e.g. the 1 Hz, 50 % duty-cycle output of the board clock divider.
- Samples the slow clock in the 100 MHz clkin domain, detects its edges and measures every half-period in clkin cycles.
- Declares lock after consecutive in-tolerance half-periods; flags period errors and loss of toggling.
- Used on-board for self-check and in simulation as the scoreboard for divider outputs.

Parameters:
- EXP_HALF, 50000000, expected half-period in clkin cycles.
- TOL, 1000, allowed absolute deviation of a half-period from EXP_HALF, in cycles.
- LOCK_COUNT, 4, consecutive good half-periods required for lock (>=1).
- CNT_W, 27, counter/measurement width; must hold 2*EXP_HALF.

Ports:
- clkin  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-high reset.
- clk_slow  input  1  slow clock under test; asynchronous to clkin.
- clear_err  input  1  synchronous clear of period_err.
- rise_pulse  output  1  one-cycle pulse per detected slow-clock rising edge.
- fall_pulse  output  1  one-cycle pulse per detected slow-clock falling edge.
- half_count  output  CNT_W  last measured half-period, in clkin cycles.
- meas_valid  output  1  one-cycle pulse when half_count updates.
- locked  output  1  LOCK_COUNT consecutive good half-periods seen; no error since.
- period_err  output  1  sticky: out-of-tolerance half-period or timeout.
- timeout  output  1  no edge for 2*EXP_HALF cycles; level, held while in LOST.

Behaviour:
- Reset: reset and clock are decided as "reset reset, asynchronous, active-high; clock clkin".
  - All outputs go to 0 immediately on reset.
  - Sync flops, previous-sample flop, counter and good-run counter go to 0.
  - State goes to IDLE.
- Synchronizer: 2 flops, then a previous-sample register.
  - edge_rise = sync2 & ~prev; edge_fall = ~sync2 & prev.
  - rise_pulse/fall_pulse are registered. Each pulse is high for exactly 1 cycle, on the 3rd clkin rising edge after the input transition is first sampled.
  - If clk_slow is high out of reset, a rise is detected (prev resets to 0).
- States:
  - IDLE: counter held at 0. On any edge, go to MEASURE with cnt <= 0; no measurement is produced for this edge.
  - MEASURE: cnt increments every cycle, saturating at all-ones. On an edge:
    - half_count <= cnt+1, so edges exactly N cycles apart report N.
    - meas_valid pulses in the same cycle as rise_pulse/fall_pulse; cnt <= 0.
    - Good half (|cnt+1 - EXP_HALF| <= TOL): good_run increments, saturating at LOCK_COUNT. When it reaches LOCK_COUNT, locked <= 1 and the state goes to LOCKED.
    - Bad half: period_err <= 1, good_run <= 0, stay in MEASURE.
  - LOCKED: measures as in MEASURE. A bad half sets period_err, clears locked and good_run, and returns to MEASURE.
  - LOST: entered from MEASURE or LOCKED when cnt == 2*EXP_HALF-1 with no edge in that cycle.
    - timeout <= 1, period_err <= 1, locked <= 0, good_run <= 0.
    - The next edge clears timeout and goes to MEASURE with cnt <= 0 (restart, no measurement).
- Arithmetic: the deviation compare uses unsigned magnitude in CNT_W+1 bits; no wrap. The counter saturates and never wraps.
- Simultaneous events:
  - Edge and timeout threshold in the same cycle: the edge wins, no timeout.
  - clear_err together with a new error: the error wins, period_err stays 1.
  - clear_err has no effect on locked or timeout.
- Reset mid-measurement: the partial measurement is discarded; the next edge after reset is treated as a first edge.

Test Plan:
(bench parameters EXP_HALF=10, TOL=1, LOCK_COUNT=4)
1. clk_slow toggles every 10 clkin cycles from reset -> first edge gives no meas_valid. Each subsequent edge gives meas_valid with half_count=10. locked=1 on the 5th edge; period_err=0.
2. After lock, one half-period of 12 cycles -> meas_valid with half_count=12, period_err=1, locked=0. Four further 10-cycle halves re-assert locked; period_err stays 1 until clear_err.
3. Halves alternating 11 and 9 -> all good; locked=1 on the 5th edge. A half of 8 -> period_err=1.
4. Locked, then clk_slow stops -> timeout=1 and locked=0 exactly 20 cycles after the last detected edge pulse. The next edge clears timeout without producing meas_valid.
5. clear_err asserted in the same cycle as a 13-cycle measurement -> period_err remains 1. clear_err the following cycle -> period_err=0.
6. reset asserted mid-half (cnt=5) while locked -> all outputs 0 asynchronously. After release with clk_slow high, rise_pulse appears 3 cycles later with no meas_valid; latency from input change to rise_pulse is exactly 3 clkin cycles.

Source files
------------

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor
// Receive-side checker for a divided slow clock (e.g. a 1 Hz, 50 % duty
// output of the board clock divider). The slow clock is synchronised into
// the clkin domain, its edges are detected and every half-period is measured
// in clkin cycles. Lock is declared after LOCK_COUNT consecutive
// in-tolerance half-periods; out-of-tolerance halves and loss of toggling
// raise a sticky period error.
//
// Ports:
//   clkin      in   system clock (100 MHz)
//   reset      in   asynchronous, active-high reset
//   clk_slow   in   slow clock under test, asynchronous to clkin
//   clear_err  in   synchronous clear of period_err
//   rise_pulse out  one-cycle pulse per detected slow-clock rising edge
//   fall_pulse out  one-cycle pulse per detected slow-clock falling edge
//   half_count out  last measured half-period in clkin cycles
//   meas_valid out  one-cycle pulse when half_count updates
//   locked     out  LOCK_COUNT consecutive good halves seen, no error since
//   period_err out  sticky: out-of-tolerance half-period or timeout
//   timeout    out  no edge for 2*EXP_HALF cycles; held while in LOST
module slow_clock_monitor #(
  parameter int unsigned EXP_HALF   = 50000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 27
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             clk_slow,
  input  logic             clear_err,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_count,
  output logic             meas_valid,
  output logic             locked,
  output logic             period_err,
  output logic             timeout
);

  localparam int unsigned GR_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GR_W-1:0]  GR_MAX   = GR_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(2 * EXP_HALF - 1);
  localparam logic [CNT_W:0]   EXP_EXT  = (CNT_W + 1)'(EXP_HALF);
  localparam logic [CNT_W:0]   TOL_EXT  = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED,
    LOST
  } state_e;

  logic             sync1_q, sync2_q, prev_q;
  logic             rise_q, fall_q;
  logic             edge_rise, edge_fall, edge_any;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GR_W-1:0]  good_run_q, good_run_d;
  logic [CNT_W-1:0] half_count_q, half_count_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             period_err_q, period_err_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W:0]   meas_ext;
  logic [CNT_W:0]   deviation;
  logic             half_good;
  logic [CNT_W-1:0] cnt_sat_inc;
  logic [GR_W-1:0]  gr_inc;
  logic             err_set;

  // Two-flop synchroniser plus previous-sample register. prev resets to 0
  // so a slow clock that is already high out of reset reads as a rise.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= clk_slow;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= edge_rise;
      fall_q  <= edge_fall;
    end
  end

  assign edge_rise = sync2_q & ~prev_q;
  assign edge_fall = ~sync2_q & prev_q;
  assign edge_any  = edge_rise | edge_fall;

  // Measurement arithmetic: cnt+1 is formed one bit wider so the deviation
  // magnitude can never wrap, even with a saturated counter.
  always_comb begin
    meas_ext    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    deviation   = (meas_ext >= EXP_EXT) ? (meas_ext - EXP_EXT) : (EXP_EXT - meas_ext);
    half_good   = (deviation <= TOL_EXT);
    cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    gr_inc      = (good_run_q == GR_MAX) ? good_run_q : good_run_q + GR_W'(1);
  end

  // Next-state logic. An edge always takes priority over the timeout
  // threshold, and a new error always beats clear_err.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    good_run_d   = good_run_q;
    half_count_d = half_count_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    err_set      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edge_any) begin
          state_d = MEASURE;
        end
      end

      MEASURE, LOCKED: begin
        if (edge_any) begin
          cnt_d        = '0;
          half_count_d = cnt_sat_inc;
          meas_valid_d = 1'b1;
          if (half_good) begin
            good_run_d = gr_inc;
            if (gr_inc == GR_MAX) begin
              locked_d = 1'b1;
              state_d  = LOCKED;
            end
          end else begin
            err_set    = 1'b1;
            good_run_d = '0;
            locked_d   = 1'b0;
            state_d    = MEASURE;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d    = LOST;
          cnt_d      = '0;
          timeout_d  = 1'b1;
          err_set    = 1'b1;
          locked_d   = 1'b0;
          good_run_d = '0;
        end else begin
          cnt_d = cnt_sat_inc;
        end
      end

      LOST: begin
        cnt_d = '0;
        if (edge_any) begin
          timeout_d = 1'b0;
          state_d   = MEASURE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    period_err_d = err_set | (period_err_q & ~clear_err);
  end

  // State and measurement registers.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      good_run_q   <= '0;
      half_count_q <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_run_q   <= good_run_d;
      half_count_q <= half_count_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      period_err_q <= period_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign half_count = half_count_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign period_err = period_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb_slow_clock_monitor
// Self-checking bench for slow_clock_monitor with EXP_HALF=10, TOL=1,
// LOCK_COUNT=4. A table of half-period gaps drives clk_slow; for every
// toggle the expected edge-time outputs are queued and a monitor pops and
// compares them when the DUT reports the edge. Timeout, clear_err overlap
// and mid-measurement reset are covered by hand-written sequences.
module tb_slow_clock_monitor;

  localparam int unsigned CNT_W = 8;

  logic             clkin;
  logic             reset;
  logic             clk_slow;
  logic             clear_err;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] half_count;
  logic             meas_valid;
  logic             locked;
  logic             period_err;
  logic             timeout;

  typedef struct {
    int gap;
    bit clr;
    bit rst;
    bit expValid;
    int expCount;
    bit expLocked;
    bit expErr;
  } vec_t;

  typedef struct {
    bit rise;
    bit valid;
    int count;
    bit locked;
    bit err;
    bit tmo;
  } sb_t;

  sb_t  sbQueue[$];
  sb_t  sbExp;
  vec_t vecs[23];
  int   checkCount = 0;
  int   passCount  = 0;
  int   spent      = 0;

  slow_clock_monitor #(
    .EXP_HALF  (10),
    .TOL       (1),
    .LOCK_COUNT(4),
    .CNT_W     (CNT_W)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .clk_slow  (clk_slow),
    .clear_err (clear_err),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .half_count(half_count),
    .meas_valid(meas_valid),
    .locked    (locked),
    .period_err(period_err),
    .timeout   (timeout)
  );

  // 100 MHz clock.
  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    else
      passCount++;
  endtask

  function automatic vec_t mk(int gap, bit clr, bit rst, bit v, int cnt, bit lk, bit er);
    vec_t r;
    r.gap = gap; r.clr = clr; r.rst = rst;
    r.expValid = v; r.expCount = cnt; r.expLocked = lk; r.expErr = er;
    return r;
  endfunction

  task automatic resetDut();
    @(negedge clkin);
    reset     = 1'b1;
    clk_slow  = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(negedge clkin);
    reset = 1'b0;
    spent = 0;
  endtask

  // Wait the remaining gap, toggle clk_slow and queue the expected edge
  // outputs. With clr set, clear_err is held over the measurement cycle and
  // the one after it, then period_err must read back as cleared.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    if (v.rst) resetDut();
    repeat (v.gap - spent) @(negedge clkin);
    clk_slow = ~clk_slow;
    e.rise = clk_slow; e.valid = v.expValid; e.count = v.expCount;
    e.locked = v.expLocked; e.err = v.expErr; e.tmo = 1'b0;
    sbQueue.push_back(e);
    spent = 0;
    if (v.clr) begin
      repeat (2) @(negedge clkin);
      clear_err = 1'b1;
      repeat (2) @(negedge clkin);
      clear_err = 1'b0;
      checkOutput("errClearedNextCycle", int'(period_err), 0);
      spent = 4;
    end
  endtask

  // Scoreboard monitor: compare queued expectations at each detected edge.
  always @(posedge clkin) begin
    #1;
    if (!reset && (rise_pulse || fall_pulse)) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sbUnexpectedPulse", 1, 0);
      end else begin
        sbExp = sbQueue.pop_front();
        checkOutput("sbRisePulse", int'(rise_pulse), int'(sbExp.rise));
        checkOutput("sbFallPulse", int'(fall_pulse), int'(!sbExp.rise));
        checkOutput("sbMeasValid", int'(meas_valid), int'(sbExp.valid));
        checkOutput("sbHalfCount", int'(half_count), sbExp.count);
        checkOutput("sbLocked", int'(locked), int'(sbExp.locked));
        checkOutput("sbPeriodErr", int'(period_err), int'(sbExp.err));
        checkOutput("sbTimeout", int'(timeout), int'(sbExp.tmo));
      end
    end
  end

  initial begin
    // gap, clr, rst, expValid, expCount, expLocked, expErr
    vecs[0]  = mk(3,  0, 0, 0, 0,  0, 0);
    vecs[1]  = mk(10, 0, 0, 1, 10, 0, 0);
    vecs[2]  = mk(10, 0, 0, 1, 10, 0, 0);
    vecs[3]  = mk(10, 0, 0, 1, 10, 0, 0);
    vecs[4]  = mk(10, 0, 0, 1, 10, 1, 0);
    vecs[5]  = mk(10, 0, 0, 1, 10, 1, 0);
    vecs[6]  = mk(12, 0, 0, 1, 12, 0, 1);
    vecs[7]  = mk(10, 0, 0, 1, 10, 0, 1);
    vecs[8]  = mk(10, 0, 0, 1, 10, 0, 1);
    vecs[9]  = mk(10, 0, 0, 1, 10, 0, 1);
    vecs[10] = mk(10, 0, 0, 1, 10, 1, 1);
    vecs[11] = mk(10, 1, 0, 1, 10, 1, 0);
    vecs[12] = mk(3,  0, 1, 0, 0,  0, 0);
    vecs[13] = mk(11, 0, 0, 1, 11, 0, 0);
    vecs[14] = mk(9,  0, 0, 1, 9,  0, 0);
    vecs[15] = mk(11, 0, 0, 1, 11, 0, 0);
    vecs[16] = mk(9,  0, 0, 1, 9,  1, 0);
    vecs[17] = mk(8,  0, 0, 1, 8,  0, 1);
    vecs[18] = mk(13, 1, 0, 1, 13, 0, 1);
    vecs[19] = mk(10, 0, 0, 1, 10, 0, 0);
    vecs[20] = mk(10, 0, 0, 1, 10, 0, 0);
    vecs[21] = mk(10, 0, 0, 1, 10, 0, 0);
    vecs[22] = mk(10, 0, 0, 1, 10, 1, 0);

    reset     = 1'b1;
    clk_slow  = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(negedge clkin);
    checkOutput("rstRisePulse", int'(rise_pulse), 0);
    checkOutput("rstFallPulse", int'(fall_pulse), 0);
    checkOutput("rstHalfCount", int'(half_count), 0);
    checkOutput("rstMeasValid", int'(meas_valid), 0);
    checkOutput("rstLocked", int'(locked), 0);
    checkOutput("rstPeriodErr", int'(period_err), 0);
    checkOutput("rstTimeout", int'(timeout), 0);
    reset = 1'b0;
    spent = 0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Loss of toggling: timeout exactly 20 cycles after the last edge pulse.
    repeat (22) @(negedge clkin);
    checkOutput("preTimeoutFlag", int'(timeout), 0);
    checkOutput("preTimeoutLocked", int'(locked), 1);
    @(negedge clkin);
    checkOutput("timeoutFlag", int'(timeout), 1);
    checkOutput("timeoutLocked", int'(locked), 0);
    checkOutput("timeoutErr", int'(period_err), 1);

    // Restart edge clears timeout with no measurement, then relock.
    applyStimulus(mk(5,  0, 0, 0, 10, 0, 1));
    applyStimulus(mk(10, 0, 0, 1, 10, 0, 1));
    applyStimulus(mk(10, 0, 0, 1, 10, 0, 1));
    applyStimulus(mk(10, 0, 0, 1, 10, 0, 1));
    applyStimulus(mk(10, 0, 0, 1, 10, 1, 1));

    // Reset mid-half (cnt=5) while locked, with clk_slow high across reset.
    repeat (8) @(negedge clkin);
    checkOutput("midHalfLocked", int'(locked), 1);
    reset    = 1'b1;
    clk_slow = 1'b1;
    #1;
    checkOutput("asyncRstLocked", int'(locked), 0);
    checkOutput("asyncRstErr", int'(period_err), 0);
    checkOutput("asyncRstHalfCount", int'(half_count), 0);
    checkOutput("asyncRstMeasValid", int'(meas_valid), 0);
    checkOutput("asyncRstPulses", int'(rise_pulse | fall_pulse), 0);
    checkOutput("asyncRstTimeout", int'(timeout), 0);
    repeat (2) @(negedge clkin);
    reset = 1'b0;
    sbQueue.push_back('{rise: 1'b1, valid: 1'b0, count: 0, locked: 1'b0, err: 1'b0, tmo: 1'b0});
    repeat (2) @(negedge clkin);
    checkOutput("riseLatencyEarly", int'(rise_pulse), 0);
    @(negedge clkin);
    checkOutput("riseLatencyExact", int'(rise_pulse), 1);
    repeat (2) @(negedge clkin);
    clk_slow = 1'b0;
    sbQueue.push_back('{rise: 1'b0, valid: 1'b1, count: 5, locked: 1'b0, err: 1'b1, tmo: 1'b0});
    repeat (2) @(negedge clkin);
    checkOutput("fallLatencyEarly", int'(fall_pulse), 0);
    @(negedge clkin);
    checkOutput("fallLatencyExact", int'(fall_pulse), 1);

    repeat (5) @(negedge clkin);
    checkOutput("sbAllEdgesSeen", sbQueue.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
